// File: rtl/cmsdk_uart_wb.sv
// Wishbone-attached 8N1 UART with a CMSDK-style register map and ID block.
// Single-entry TX/RX buffers; interrupt status is visible only through INTSTATUS.
module cmsdk_uart_wb (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_dev_sel,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [9:0]  i_wb_adr,
  input  logic [19:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  input  logic        i_rxd,
  output logic        o_txd,
  output logic        o_txen
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_e;

  logic        r_ack;
  logic [31:0] r_rdat;
  logic [6:0]  r_ctrl;
  logic [19:0] r_baud;
  logic [7:0]  r_txbuf, r_rxbuf;
  logic        r_txfull, r_txovr, r_rxfull, r_rxovr;
  logic [3:0]  r_int;

  logic        w_req, w_wr, w_rd;
  logic        w_wr_data, w_wr_state, w_wr_ctrl, w_wr_int, w_wr_baud, w_rd_data;
  logic [31:0] w_rdata;
  logic        w_run;

  assign w_req      = i_dev_sel & i_wb_cyc & ~r_ack;
  assign w_wr       = w_req & i_wb_we;
  assign w_rd       = w_req & ~i_wb_we;
  assign w_wr_data  = w_wr && (i_wb_adr == 10'h000);
  assign w_wr_state = w_wr && (i_wb_adr == 10'h001);
  assign w_wr_ctrl  = w_wr && (i_wb_adr == 10'h002);
  assign w_wr_int   = w_wr && (i_wb_adr == 10'h003);
  assign w_wr_baud  = w_wr && (i_wb_adr == 10'h004);
  assign w_rd_data  = w_rd && (i_wb_adr == 10'h000);
  assign w_run      = (r_baud >= 20'd16);

  assign o_wb_ack = r_ack;
  assign o_wb_dat = r_rdat;
  assign o_txen   = r_ctrl[0];

  always_comb begin
    w_rdata = 32'h0;
    case (i_wb_adr)
      10'h000: w_rdata = {24'h0, r_rxbuf};
      10'h001: w_rdata = {28'h0, r_rxovr, r_txovr, r_rxfull, r_txfull};
      10'h002: w_rdata = {25'h0, r_ctrl};
      10'h003: w_rdata = {28'h0, r_int};
      10'h004: w_rdata = {12'h0, r_baud};
      10'h3F4: w_rdata = 32'h04;
      10'h3F8: w_rdata = 32'h21;
      10'h3F9: w_rdata = 32'hB8;
      10'h3FA: w_rdata = 32'h1B;
      10'h3FB: w_rdata = 32'h00;
      10'h3FC: w_rdata = 32'h0D;
      10'h3FD: w_rdata = 32'hF0;
      10'h3FE: w_rdata = 32'h05;
      10'h3FF: w_rdata = 32'hB1;
      default: w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ack  <= 1'b0;
      r_rdat <= 32'h0;
    end else begin
      r_ack  <= w_req;
      r_rdat <= w_rd ? w_rdata : 32'h0;
    end
  end

  // ---------------- transmitter ----------------
  uart_st_e    r_tx_st, w_tx_next;
  logic [19:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_sh;
  logic        w_tx_tick, w_tx_load;

  assign w_tx_tick = (r_tx_cnt == r_baud - 20'd1);

  always_comb begin
    w_tx_next = r_tx_st;
    w_tx_load = 1'b0;
    if (!w_run) w_tx_next = S_IDLE;
    else begin
      case (r_tx_st)
        S_IDLE:  if (r_ctrl[0] && r_txfull) begin
                   w_tx_load = 1'b1;
                   w_tx_next = S_START;
                 end
        S_START: if (w_tx_tick) w_tx_next = S_DATA;
        S_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = S_STOP;
        // Reload straight from STOP so consecutive frames abut.
        S_STOP:  if (w_tx_tick) begin
                   if (r_ctrl[0] && r_txfull) begin
                     w_tx_load = 1'b1;
                     w_tx_next = S_START;
                   end else w_tx_next = S_IDLE;
                 end
        default: w_tx_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_tx_st <= S_IDLE;
    else            r_tx_st <= w_tx_next;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tx_cnt <= 20'h0;
      r_tx_bit <= 3'h0;
      r_tx_sh  <= 8'h0;
    end else begin
      if (!w_run || r_tx_st == S_IDLE || w_tx_tick) r_tx_cnt <= 20'h0;
      else                                          r_tx_cnt <= r_tx_cnt + 20'd1;
      if (w_tx_load) begin
        r_tx_sh  <= r_txbuf;
        r_tx_bit <= 3'h0;
      end else if (r_tx_st == S_DATA && w_tx_tick) begin
        r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
        r_tx_bit <= r_tx_bit + 3'd1;
      end
    end
  end

  always_comb begin
    o_txd = 1'b1;
    case (r_tx_st)
      S_START: o_txd = 1'b0;
      S_DATA:  o_txd = r_tx_sh[0];
      default: o_txd = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  uart_st_e    r_rx_st, w_rx_next;
  logic        r_rx_s1, r_rx_s2, r_rx_d;
  logic [19:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_sh;
  logic        w_rx_fall, w_rx_half, w_rx_tick, w_rx_shift, w_rx_done;

  assign w_rx_fall = r_rx_d & ~r_rx_s2;
  assign w_rx_half = (r_rx_cnt == (r_baud >> 1));
  assign w_rx_tick = (r_rx_cnt == r_baud - 20'd1);

  always_comb begin
    w_rx_next  = r_rx_st;
    w_rx_shift = 1'b0;
    w_rx_done  = 1'b0;
    if (!w_run) w_rx_next = S_IDLE;
    else begin
      case (r_rx_st)
        S_IDLE:  if (r_ctrl[1] && w_rx_fall) w_rx_next = S_START;
        S_START: if (w_rx_half) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
        S_DATA:  if (w_rx_tick) begin
                   w_rx_shift = 1'b1;
                   if (r_rx_bit == 3'd7) w_rx_next = S_STOP;
                 end
        S_STOP:  if (w_rx_tick) begin
                   w_rx_done = r_rx_s2;
                   w_rx_next = S_IDLE;
                 end
        default: w_rx_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_rx_st <= S_IDLE;
    else            r_rx_st <= w_rx_next;
  end

  // Synchronizer resets to the idle line level so reset release is not seen as a start edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_d   <= 1'b1;
      r_rx_cnt <= 20'h0;
      r_rx_bit <= 3'h0;
      r_rx_sh  <= 8'h0;
    end else begin
      r_rx_s1 <= i_rxd;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
      if (r_rx_st == S_IDLE || w_rx_next != r_rx_st || w_rx_tick) r_rx_cnt <= 20'h0;
      else                                                       r_rx_cnt <= r_rx_cnt + 20'd1;
      if (r_rx_st == S_IDLE) r_rx_bit <= 3'h0;
      else if (w_rx_shift) begin
        r_rx_bit <= r_rx_bit + 3'd1;
        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
      end
    end
  end

  // ---------------- registers and flags (set beats clear) ----------------
  logic       w_txovr_set, w_rxovr_set;
  logic [3:0] w_int_set, w_int_clr;

  assign w_txovr_set = w_wr_data & r_txfull;
  assign w_rxovr_set = w_rx_done & r_rxfull;
  assign w_int_set   = {w_rxovr_set & r_ctrl[5], w_txovr_set & r_ctrl[4],
                        w_rx_done & r_ctrl[3],   w_tx_load & r_ctrl[2]};
  assign w_int_clr   = w_wr_int ? i_wb_dat[3:0] : 4'h0;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ctrl   <= 7'h0;
      r_baud   <= 20'h0;
      r_txbuf  <= 8'h0;
      r_rxbuf  <= 8'h0;
      r_txfull <= 1'b0;
      r_txovr  <= 1'b0;
      r_rxfull <= 1'b0;
      r_rxovr  <= 1'b0;
      r_int    <= 4'h0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= i_wb_dat[6:0];
      if (w_wr_baud) r_baud <= i_wb_dat;
      if (w_wr_data && !r_txfull) begin
        r_txbuf  <= i_wb_dat[7:0];
        r_txfull <= 1'b1;
      end else if (w_tx_load) r_txfull <= 1'b0;
      if (w_txovr_set)                   r_txovr <= 1'b1;
      else if (w_wr_state && i_wb_dat[2]) r_txovr <= 1'b0;
      if (w_rx_done) begin
        r_rxbuf  <= r_rx_sh;
        r_rxfull <= 1'b1;
      end else if (w_rd_data) r_rxfull <= 1'b0;
      if (w_rxovr_set)                   r_rxovr <= 1'b1;
      else if (w_wr_state && i_wb_dat[3]) r_rxovr <= 1'b0;
      r_int <= (r_int & ~w_int_clr) | w_int_set;
    end
  end

endmodule

// File: tb/tb_cmsdk_uart_wb.sv
// Directed bench for cmsdk_uart_wb: bus handshake, ID block, TX/RX framing, flags, halt.
module tb_cmsdk_uart_wb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel, cyc, we;
  logic [9:0]  adr;
  logic [19:0] wdat;
  logic [31:0] rdat;
  logic        ack, rxd, txd, txen;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [9:0] A_DATA = 10'h000, A_STATE = 10'h001, A_CTRL = 10'h002,
                         A_INT  = 10'h003, A_BAUD  = 10'h004;

  always #5 clk = ~clk;

  cmsdk_uart_wb dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_dev_sel(sel), .i_wb_cyc(cyc), .i_wb_we(we),
    .i_wb_adr(adr), .i_wb_dat(wdat), .o_wb_dat(rdat), .o_wb_ack(ack),
    .i_rxd(rxd), .o_txd(txd), .o_txen(txen)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wb_wr(input logic [9:0] a, input logic [19:0] d);
    @(negedge clk); sel = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; wdat = d;
    @(posedge clk);
    @(negedge clk); sel = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [9:0] a, input logic [31:0] exp);
    logic [31:0] d;
    @(negedge clk); sel = 1'b1; cyc = 1'b1; we = 1'b0; adr = a;
    @(posedge clk); #1 d = rdat;
    @(negedge clk); sel = 1'b0; cyc = 1'b0;
    chk(tag, d, exp);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    @(negedge clk); rxd = 1'b0;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (32) @(negedge clk);
    end
    rxd = stop;
    repeat (32) @(negedge clk);
    rxd = 1'b1;
    repeat (32) @(negedge clk);
  endtask

  initial begin
    logic [7:0] txb;
    bit         seen;
    int         lows;
    rst_n = 1'b0; sel = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; wdat = '0; rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    chk("rst_txd", txd, 1'b1);
    chk("rst_ack", ack, 1'b0);
    chk("rst_dat", rdat, 32'h0);
    chk("rst_txen", txen, 1'b0);
    rd_chk("rst_state", A_STATE, 32'h0);
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rst_baud", A_BAUD, 32'h0);
    rd_chk("pid0", 10'h3F8, 32'h21);
    rd_chk("pid4", 10'h3F4, 32'h04);
    rd_chk("cid3", 10'h3FF, 32'hB1);

    // held cycle: ack is a single pulse one cycle after request
    @(negedge clk); sel = 1'b1; cyc = 1'b1; we = 1'b0; adr = 10'h3F9;
    #1 chk("ack_not_early", ack, 1'b0);
    @(posedge clk); #1;
    chk("ack_pulse", ack, 1'b1);
    chk("ack_dat", rdat, 32'hB8);
    @(posedge clk); #1;
    chk("ack_drop", ack, 1'b0);
    chk("ack_dat_drop", rdat, 32'h0);
    @(negedge clk); sel = 1'b0; cyc = 1'b0;

    // TX frame 0xA5 at 16 cycles per bit
    wb_wr(A_BAUD, 20'd16);
    wb_wr(A_CTRL, 20'h05);
    chk("txen_out", txen, 1'b1);
    wb_wr(A_DATA, 20'hA5);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (txd == 1'b0) seen = 1'b1;
    end
    chk("tx_start_seen", seen, 1'b1);
    repeat (8) @(posedge clk); #1;
    chk("tx_start_bit", txd, 1'b0);
    txb = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(posedge clk); #1;
      chk($sformatf("tx_bit%0d", i), txd, txb[i]);
    end
    repeat (16) @(posedge clk); #1;
    chk("tx_stop_bit", txd, 1'b1);
    repeat (20) @(posedge clk);
    rd_chk("tx_int", A_INT, 32'h1);
    wb_wr(A_INT, 20'h1);
    rd_chk("tx_int_clr", A_INT, 32'h0);
    rd_chk("tx_state_empty", A_STATE, 32'h0);

    // TX overrun: first byte goes to the shifter, second buffers, third overruns
    wb_wr(A_DATA, 20'h11);
    wb_wr(A_DATA, 20'h22);
    wb_wr(A_DATA, 20'h33);
    rd_chk("txovr_state", A_STATE, 32'h5);
    wb_wr(A_STATE, 20'h4);
    rd_chk("txovr_clr", A_STATE, 32'h1);
    repeat (400) @(posedge clk);
    rd_chk("tx_drained", A_STATE, 32'h0);
    wb_wr(A_INT, 20'hF);
    wb_wr(A_CTRL, 20'h00);

    // RX at 32 cycles per bit
    wb_wr(A_BAUD, 20'd32);
    wb_wr(A_CTRL, 20'h0A);
    rd_chk("ctrl_rb", A_CTRL, 32'h0A);
    rx_frame(8'h3C, 1'b1);
    rd_chk("rx_state", A_STATE, 32'h2);
    rd_chk("rx_int", A_INT, 32'h2);
    rd_chk("rx_data", A_DATA, 32'h3C);
    rd_chk("rx_state_rd", A_STATE, 32'h0);

    // RX overrun keeps the newer byte
    rx_frame(8'h5A, 1'b1);
    rx_frame(8'hC3, 1'b1);
    rd_chk("rxovr_state", A_STATE, 32'hA);
    rd_chk("rxovr_data", A_DATA, 32'hC3);
    rd_chk("rxovr_after_rd", A_STATE, 32'h8);
    wb_wr(A_STATE, 20'h8);
    rd_chk("rxovr_clr", A_STATE, 32'h0);
    wb_wr(A_INT, 20'hF);

    // framing error: byte discarded, no flags
    rx_frame(8'h77, 1'b0);
    rd_chk("ferr_state", A_STATE, 32'h0);
    rd_chk("ferr_int", A_INT, 32'h0);
    rd_chk("ferr_data", A_DATA, 32'hC3);

    // divisor below 16 halts the transmitter
    wb_wr(A_BAUD, 20'd8);
    wb_wr(A_CTRL, 20'h01);
    wb_wr(A_DATA, 20'h55);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (txd == 1'b0) lows++;
    end
    chk("halt_txd_low_cycles", lows, 0);
    rd_chk("halt_state", A_STATE, 32'h1);
    rd_chk("halt_baud_rb", A_BAUD, 32'd8);

    // short low glitch is rejected by the start-bit check
    wb_wr(A_CTRL, 20'h0A);
    wb_wr(A_BAUD, 20'd32);
    @(negedge clk); rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    rd_chk("glitch_state", A_STATE, 32'h1);
    rd_chk("glitch_int", A_INT, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cmsdk_uart_wb.md
Name: cmsdk_uart_wb

Overview:
- Wishbone-attached UART (CMSDK-style register map), 8N1 frames, programmable baud divisor.
- Sits as slave 1 of the main NIC at 0x1xxx_xxxx and drives the board TX/RX pins.
- NIC decode arrives on i_dev_sel; word address is bus address bits [11:2].
- Single-entry TX and RX buffers with overrun flags and internal interrupt status; no interrupt output pins.

Parameters:
- none (register map and frame format are fixed)

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_dev_sel  in  1  NIC slave select
- i_wb_cyc  in  1  bus cycle active
- i_wb_we  in  1  1 = write, 0 = read
- i_wb_adr  in  10  word address (byte address [11:2])
- i_wb_dat  in  20  write data, low 20 bits
- o_wb_dat  out  32  read data
- o_wb_ack  out  1  transfer acknowledge
- i_rxd  in  1  serial receive, asynchronous, idle high
- o_txd  out  1  serial transmit, idle high
- o_txen  out  1  transmitter enable (= CTRL[0])

Behaviour:
Reset:
- All registers 0; o_txd=1; o_wb_ack=0; o_wb_dat=0; RX/TX FSMs IDLE.

Bus handshake:
- Request = i_dev_sel & i_wb_cyc & !o_wb_ack.
- On request: o_wb_ack=1 next cycle for exactly one cycle, with o_wb_dat registered in the same edge.
- Write side effects occur on the request edge only, so a held cycle causes exactly one effect.
- Other cycles: o_wb_dat=0.

Register map (byte offset):
- 0x000 DATA
  - W: if TX buffer empty, load [7:0] and set TXFULL; else set TXOVR, buffer unchanged.
  - R: {24'b0, rxbuf}; clears RXFULL.
- 0x004 STATE, R {28'b0, RXOVR, TXOVR, RXFULL, TXFULL}.
  - W: 1 in bit2 clears TXOVR; 1 in bit3 clears RXOVR.
- 0x008 CTRL, R/W [6:0].
  - Bits: 0 TXEN, 1 RXEN, 2 TXIE, 3 RXIE, 4 TXOVRIE, 5 RXOVRIE, 6 reserved (stored, no function).
- 0x00C INTSTATUS / INTCLEAR
  - R {28'b0, RXOVRINT, TXOVRINT, RXINT, TXINT}.
  - W: write-1-to-clear.
- 0x010 BAUDDIV, R/W [19:0].
- ID block:
  - 0xFD0 PID4=0x04; 0xFE0..0xFEC PID0..3 = 0x21, 0xB8, 0x1B, 0x00.
  - 0xFF0..0xFFC CID0..3 = 0x0D, 0xF0, 0x05, 0xB1.
- All other offsets read 0; writes ignored.

Baud:
- Bit period = BAUDDIV clock cycles.
- BAUDDIV < 16 halts both FSMs (held in IDLE, o_txd=1).

TX:
- FSM IDLE -> START -> DATA0..7 (LSB first) -> STOP -> IDLE; each state lasts one bit period.
- In IDLE with TXEN=1 and TXFULL=1: copy buffer to shifter, clear TXFULL, enter START next cycle.
- Loading the shifter sets TXINT if TXIE.
- The buffer may be refilled during shifting; back-to-back frames have no idle gap.
- Clearing TXEN mid-frame completes the current frame.

RX:
- i_rxd passes a 2-flop synchronizer.
- With RXEN=1, a falling edge in IDLE starts timing.
- At BAUDDIV/2 (integer): sample start; if high, return to IDLE (glitch).
- Then sample 8 data bits LSB first and the stop bit at one-bit-period intervals.
- Stop=1: write rxbuf; set RXFULL and RXINT (if RXIE). If RXFULL was already set, set RXOVR, RXOVRINT (if RXOVRIE) and overwrite rxbuf.
- Stop=0: discard the byte; no flags change.

Interrupt and overrun flags:
- TXOVR sets TXOVRINT if TXOVRIE.
- Set and clear of the same flag in the same cycle: set wins.

o_txen:
- Combinational copy of CTRL[0].

Test Plan:
- Reset, then read 0x004/0x008/0x010/0xFE0 -> 0, 0, 0, 0x21; o_txd=1; ack is a one-cycle pulse, 1 cycle after cyc&sel.
- BAUDDIV=16, CTRL=0x05, write DATA=0xA5 -> o_txd: start 0, bits 1,0,1,0,0,1,0,1 and stop 1, each 16 cycles; INTSTATUS bit0=1; writing 1 to 0x00C clears it.
- TX enabled, write DATA twice while the first is still buffered -> STATE=0x5; write 0x4 to STATE -> 0x1.
- BAUDDIV=32, CTRL=0x0A, drive frame 0x3C on i_rxd -> STATE bit1=1, INTSTATUS bit1=1; read DATA=0x3C; STATE bit1 then 0.
- Two RX frames without reading -> STATE bit3=1, DATA = second byte; frame with stop=0 -> no flag change.
- BAUDDIV=8 with TXFULL -> o_txd stays 1; 2-cycle low glitch on i_rxd -> no reception.
